// File: rtl/pade_sched_pkg.sv
// Shared tag type, round-robin pick and id-width helper for the Pade exp scheduler.
package pade_sched_pkg;

    localparam int MAX_NREQ = 8;
    localparam int MAX_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One-hot grant for the first valid requester after ptr, wrapping modulo n.
    function automatic logic [MAX_NREQ-1:0] rr_pick(input logic [MAX_NREQ-1:0] valid,
                                                    input logic [MAX_ID_W-1:0] ptr,
                                                    input int n);
        logic [MAX_NREQ-1:0] grant;
        logic [MAX_ID_W-1:0] idx;
        grant = '0;
        for (int k = 1; k <= MAX_NREQ; k++) begin
            idx = MAX_ID_W'((int'(ptr) + k) % n);
            if (k <= n && grant == '0 && valid[idx]) begin
                grant[idx] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/pade_sched_fifo.sv
// First-word fall-through FIFO: registered head slot in front of a circular store,
// with a total occupancy count (head + store).
module pade_sched_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop_req,
    output logic                       head_valid,
    output logic [W-1:0]               head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] mem_count;
    logic             pop, load_head, mem_rd, mem_wr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // An empty store lets a push bypass straight into the head slot.
    always_comb begin
        pop       = head_valid && pop_req;
        load_head = !head_valid || pop;
        mem_rd    = load_head && (mem_count != '0);
        mem_wr    = push && !(load_head && (mem_count == '0));
    end

    assign count = mem_count + CNT_W'(head_valid);

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid <= 1'b0;
            head_data  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            mem_count  <= '0;
        end else begin
            if (load_head) begin
                if (mem_rd) begin
                    head_data  <= mem[rd_ptr];
                    head_valid <= 1'b1;
                end else if (push) begin
                    head_data  <= push_data;
                    head_valid <= 1'b1;
                end else begin
                    head_valid <= 1'b0;
                end
            end
            if (mem_rd) rd_ptr <= ptr_next(rd_ptr);
            if (mem_wr) wr_ptr <= ptr_next(wr_ptr);
            mem_count <= mem_count + CNT_W'(mem_wr) - CNT_W'(mem_rd);
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        !(push && (count == CNT_W'(DEPTH)) && !pop));

endmodule

// File: rtl/pade_exp_scheduler.sv
// Round-robin scheduler sharing one Pade 2^f datapath between NREQ requesters.
// Optional perf counters behind `PADE_SCHED_PERF_EN.
module pade_exp_scheduler
    import pade_sched_pkg::*;
#(
    parameter int BITS      = 16,
    parameter     PRECISION = "HALF",
    parameter int NREQ      = 4,
    parameter int LATENCY   = 23,
    parameter int DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*BITS-1:0]     req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [BITS-1:0]          dp_fpart,
    input  logic [BITS-1:0]          dp_x,
    output logic                     resp_valid,
    output logic [$clog2(NREQ)-1:0]  resp_id,
    output logic [BITS-1:0]          resp_data,
    input  logic                     resp_ready
`ifdef PADE_SCHED_PERF_EN
    ,
    output logic [31:0]              perf_issued,
    output logic [31:0]              perf_stall
`endif
);
    localparam int ID_W  = id_w(NREQ);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    if (((PRECISION == "HALF") != (BITS == 16)) || NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_cfg
        $error("pade_exp_scheduler: inconsistent BITS/PRECISION/NREQ");
    end

    tag_t                tag_pipe [LATENCY+1];
    tag_t                tag_out;
    logic [ID_W-1:0]     rr_ptr, hs_id;
    logic [CNT_W-1:0]    in_flight, fifo_count;
    logic [MAX_NREQ-1:0] grant_all;
    logic [ID_W+BITS-1:0] head;
    logic                issue_ok, hs, fifo_push;

    // Handshake on requester i when req_valid[i] && req_ready[i]; ready is offered only
    // while registered occupancy (in flight + queued) leaves a free FIFO slot.
    always_comb begin
        issue_ok  = !rst && ((OCC_W'(in_flight) + OCC_W'(fifo_count)) < OCC_W'(DEPTH));
        grant_all = rr_pick(MAX_NREQ'(req_valid), MAX_ID_W'(rr_ptr), NREQ);
        req_ready = issue_ok ? NREQ'(grant_all) : '0;
        hs        = |req_ready;
        hs_id     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) hs_id = ID_W'(i);
        end
    end

    assign tag_out   = tag_pipe[LATENCY];
    assign fifo_push = tag_out.valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            dp_fpart  <= '0;
            in_flight <= '0;
            for (int s = 0; s <= LATENCY; s++) tag_pipe[s] <= '0;
        end else begin
            if (hs) rr_ptr <= hs_id;
            dp_fpart    <= hs ? req_data[int'(hs_id)*BITS +: BITS] : '0;
            tag_pipe[0] <= tag_t'{valid: hs, id: MAX_ID_W'(hs_id)};
            for (int s = 1; s <= LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
            in_flight   <= in_flight + CNT_W'(hs) - CNT_W'(fifo_push);
        end
    end

    pade_sched_fifo #(
        .DEPTH (DEPTH),
        .W     (ID_W + BITS)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_data  ({ID_W'(tag_out.id), dp_x}),
        .pop_req    (resp_ready),
        .head_valid (resp_valid),
        .head_data  (head),
        .count      (fifo_count)
    );

    assign resp_id   = head[BITS +: ID_W];
    assign resp_data = head[BITS-1:0];

`ifdef PADE_SCHED_PERF_EN
    logic stall;
    assign stall = (|req_valid) && !issue_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (hs && perf_issued != '1) perf_issued <= perf_issued + 32'd1;
            if (stall && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
